// File: rtl/seg7_pkg.sv
// Shared types, constants and segment encoding for the 7-segment display controller.
package seg7_pkg;

    localparam int unsigned DATA_W    = 20;
    localparam int unsigned N_DIG     = 6;
    localparam int unsigned ACC_DIG   = 7;
    localparam int unsigned BIT_CNT_W = 5;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StLoad
    } state_e;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes render blank.
    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_disp_ctrl_bcd_seq_conv.sv
// Iterative double-dabble converter: one add-3/shift step per clock, 20 steps per value.
module bcd_seq_conv
    import seg7_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic [DATA_W-1:0]      value_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [4*ACC_DIG-1:0]   digits_o
);

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [4*ACC_DIG-1:0]   acc_q, acc_d;
    logic [4*ACC_DIG-1:0]   acc_adj;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(ACC_DIG); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    shift_d   = value_i;
                    acc_d     = '0;
                    bit_cnt_d = BIT_CNT_W'(DATA_W - 1);
                    state_d   = StConv;
                end
            end
            StConv: begin
                acc_d   = {acc_adj[4*ACC_DIG-2:0], shift_q[DATA_W-1]};
                shift_d = {shift_q[DATA_W-2:0], 1'b0};
                if (bit_cnt_q == '0) begin
                    state_d = StLoad;
                end else begin
                    bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                end
            end
            StLoad: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            acc_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign busy_o   = (state_q != StIdle);
    assign done_o   = (state_q == StLoad);
    assign digits_o = acc_q;

endmodule

// File: rtl/seg7_disp_ctrl.sv
// Bus-written value -> BCD conversion -> multiplexed common-anode 7-segment display.
module seg7_disp_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy_o,
    output logic              bcd_valid_o,
    output logic              ovf_o,
    output logic [N_DIG-1:0]  an_o,
    output logic [6:0]        seg_o
);

    localparam int unsigned RefCntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic                  conv_busy;
    logic                  conv_done;
    logic [4*ACC_DIG-1:0]  conv_digits;
    logic                  start;
    logic [DATA_W-1:0]     start_value;

    logic                  pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0]     pend_val_q, pend_val_d;
    logic [4*N_DIG-1:0]    disp_q, disp_d;
    logic                  ovf_q, ovf_d;
    logic [RefCntW-1:0]    ref_cnt_q, ref_cnt_d;
    logic [2:0]            scan_idx_q, scan_idx_d;
    logic [N_DIG-1:0]      an_q, an_d;
    logic [6:0]            seg_q, seg_d;

    logic                  wrap;
    logic [N_DIG-1:0]      hi_zero;
    logic [6:0]            next_seg;

    // A write arriving in the same cycle as a pending start is newer, so it wins.
    assign start       = !conv_busy && (we_i || pend_vld_q);
    assign start_value = we_i ? data_i : pend_val_q;

    bcd_seq_conv u_conv (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (start),
        .value_i  (start_value),
        .busy_o   (conv_busy),
        .done_o   (conv_done),
        .digits_o (conv_digits)
    );

    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
        if (we_i && conv_busy) begin
            pend_vld_d = 1'b1;
            pend_val_d = data_i;
        end else if (start) begin
            pend_vld_d = 1'b0;
        end
    end

    always_comb begin
        disp_d = disp_q;
        ovf_d  = ovf_q;
        if (conv_done) begin
            disp_d = conv_digits[4*N_DIG-1:0];
            ovf_d  = (conv_digits[4*ACC_DIG-1:4*N_DIG] != '0);
        end
    end

    always_comb begin
        hi_zero = '0;
        for (int k = 0; k < int'(N_DIG); k++) begin
            hi_zero[k] = ((disp_q >> (4 * k)) == '0);
        end
    end

    assign wrap = (ref_cnt_q == RefCntW'(REFRESH_DIV - 1));

    // Segment pattern is latched together with the anode at slot start.
    always_comb begin
        ref_cnt_d  = wrap ? '0 : ref_cnt_q + RefCntW'(1);
        scan_idx_d = scan_idx_q;
        an_d       = an_q;
        seg_d      = seg_q;
        next_seg   = SEG_BLANK;
        if (wrap) begin
            scan_idx_d = (scan_idx_q == 3'(N_DIG - 1)) ? 3'd0 : scan_idx_q + 3'd1;
            if (ovf_q) begin
                next_seg = SEG_DASH;
            end else if (scan_idx_d != 3'd0 && hi_zero[scan_idx_d]) begin
                next_seg = SEG_BLANK;
            end else begin
                next_seg = seg7_encode(disp_q[4*scan_idx_d +: 4]);
            end
            an_d  = ~(N_DIG'(1) << scan_idx_d);
            seg_d = next_seg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pend_vld_q <= 1'b0;
            pend_val_q <= '0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            ref_cnt_q  <= '0;
            scan_idx_q <= '0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_val_q <= pend_val_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            ref_cnt_q  <= ref_cnt_d;
            scan_idx_q <= scan_idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign busy_o      = conv_busy;
    assign bcd_valid_o = conv_done;
    assign ovf_o       = ovf_q;
    assign an_o        = an_q;
    assign seg_o       = seg_q;

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// Scoreboard bench: stimulus queues expected loads, a monitor checks each load and its scan.
module tb_seg7_disp_ctrl;

    localparam int unsigned Div = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [19:0] data;
    logic        busy;
    logic        bcd_valid;
    logic        ovf;
    logic [5:0]  an;
    logic [6:0]  seg;

    typedef struct {
        int unsigned value;
        int          slots;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   loads_seen = 0;

    always #5 clk = ~clk;

    seg7_disp_ctrl #(
        .REFRESH_DIV (Div)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .we_i        (we),
        .data_i      (data),
        .busy_o      (busy),
        .bcd_valid_o (bcd_valid),
        .ovf_o       (ovf),
        .an_o        (an),
        .seg_o       (seg)
    );

    function automatic logic [6:0] digit_pat(input int unsigned d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int unsigned v, input int k);
        int unsigned p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (v >= 1000000) return 7'b0111111;
        if (k > 0 && v < p) return 7'h7F;
        return digit_pat((v / p) % 10);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic push_exp(input int unsigned v, input int slots);
        exp_t e;
        e.value = v;
        e.slots = slots;
        exp_q.push_back(e);
    endtask

    // Waits for the next slot boundary, then checks `slots` consecutive slots.
    task automatic scan_check(input int unsigned v, input int slots);
        logic [5:0] an0;
        logic [5:0] onehot;
        int         waited;
        int         k;
        int         prev_k;
        an0    = an;
        waited = 0;
        while (an == an0 && waited < 2 * Div + 2) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("slot start v=%0d", v), an != an0, 1);
        prev_k = -1;
        for (int j = 0; j < slots; j++) begin
            if (j > 0) repeat (Div) @(negedge clk);
            k = -1;
            for (int b = 0; b < 6; b++) begin
                onehot = 6'b000001 << b;
                if (an == ~onehot) k = b;
            end
            check($sformatf("an_o one-hot-low v=%0d an=%b", v, an), k >= 0, 1);
            if (k >= 0) begin
                if (prev_k >= 0) check($sformatf("scan order v=%0d", v), k, (prev_k + 1) % 6);
                check($sformatf("seg_o v=%0d digit %0d", v, k), seg, exp_seg(v, k));
                prev_k = k;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bcd_valid === 1'b1) begin
                loads_seen++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected load: got bcd_valid_o pulse, expected none");
                end else begin
                    e = exp_q.pop_front();
                    @(negedge clk);
                    check($sformatf("ovf_o v=%0d", e.value), ovf, e.value >= 1000000);
                    check($sformatf("bcd_valid_o width v=%0d", e.value), bcd_valid, 0);
                    if (e.slots > 0) scan_check(e.value, e.slots);
                end
            end
        end
    end

    task automatic write(input int unsigned v);
        @(posedge clk);
        #1;
        we   = 1'b1;
        data = v[19:0];
        @(posedge clk);
        #1;
        we   = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || busy) && w < 500) begin
            @(posedge clk);
            w++;
        end
        check("drain within budget", w < 500, 1);
        repeat (45) @(posedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int cnt;
        int vpos;
        rst_n = 1'b0;
        we    = 1'b0;
        data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy_o", busy, 0);
        check("reset bcd_valid_o", bcd_valid, 0);
        check("reset ovf_o", ovf, 0);
        check("reset an_o", an, 6'h3F);
        check("reset seg_o", seg, 7'h7F);

        // Display stays dark until the first refresh wrap, then shows index 1.
        @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (an == 6'h3F && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check("first wrap delay", cnt, 4);
        check("first slot an_o", an, 6'b111101);

        push_exp(123456, 7);
        write(123456);
        cnt  = 0;
        vpos = -1;
        @(negedge clk);
        while (busy && cnt < 100) begin
            cnt++;
            if (bcd_valid) vpos = cnt;
            @(negedge clk);
        end
        check("busy_o cycles", cnt, 21);
        check("bcd_valid_o position", vpos, 21);
        drain();

        push_exp(42, 7);
        write(42);
        drain();
        push_exp(0, 7);
        write(0);
        drain();

        push_exp(1000000, 7);
        write(1000000);
        drain();
        push_exp(999999, 7);
        write(999999);
        drain();
        push_exp(1048575, 7);
        write(1048575);
        drain();

        // 222 is overwritten in the pending buffer by 333.
        push_exp(111, 4);
        push_exp(333, 7);
        write(111);
        repeat (4) @(posedge clk);
        write(222);
        repeat (4) @(posedge clk);
        write(333);
        drain();

        // Write sampled on the LOAD edge must be kept as pending.
        push_exp(77, 4);
        push_exp(88, 7);
        write(77);
        repeat (18) @(posedge clk);
        write(88);
        drain();

        write(555);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid-conv reset busy_o", busy, 0);
        check("mid-conv reset an_o", an, 6'h3F);
        check("mid-conv reset seg_o", seg, 7'h7F);
        check("mid-conv reset ovf_o", ovf, 0);
        check("mid-conv reset bcd_valid_o", bcd_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        scan_check(0, 7);
        repeat (30) @(posedge clk);

        check("scoreboard empty", exp_q.size(), 0);
        check("load count", loads_seen, 10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
